ahbl_slave_mem: RTL and testbench
=================================

AHBL_SLAVE_MEM -- requirements
Module: ahbl_slave_mem

Interface
REQ-001 Parameter MEM_AWIDTH, default 10; word-address width, giving 2**MEM_AWIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 0; range 0..15; wait cycles inserted per OKAY data phase.
REQ-003 Parameter ERR_BASE, default 32'hFFFF_0000; first byte address of the error region.
REQ-004 Parameter ERR_LIMIT, default 32'hFFFF_FFFF; last byte address of the error region (inclusive).
REQ-005 Port HCLK, input, 1; sole clock, rising edge.
REQ-006 Port HRESET, input, 1; reset, synchronous, active-high.
REQ-007 Port HSEL, input, 1; slave select from the BFM HSEL bus.
REQ-008 Port HADDR, input, 32; byte address.
REQ-009 Port HTRANS, input, 2; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-010 Port HWRITE, input, 1; 1=write.
REQ-011 Port HSIZE, input, 3; 000 byte, 001 half, 010 word; other codes are illegal.
REQ-012 Port HBURST, input, 3; accepted and ignored.
REQ-013 Port HWDATA, input, 32; write data, little-endian lanes.
REQ-014 Port HREADY, input, 1; bus ready, including this slave's own HREADYOUT.
REQ-015 Port HRDATA, output, 32; read data.
REQ-016 Port HREADYOUT, output, 1; 0 = extend the data phase.
REQ-017 Port HRESP, output, 1; 1 = ERROR.
REQ-018 Ports STAT_WR, STAT_RD, STAT_ERR, outputs, 16 each; completed write, read and error counts.

Function
REQ-019 Address phase accepted when HSEL & HREADY & HTRANS[1]; the module registers HADDR, HWRITE and HSIZE.
REQ-020 IDLE/BUSY, or HSEL=0, with HREADY=1: next cycle HREADYOUT=1, HRESP=0; no memory access.
REQ-021 The accepted phase is an error phase when HADDR is in [ERR_BASE,ERR_LIMIT], HSIZE>2, or HADDR is misaligned for HSIZE.
REQ-022 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-023 FSM transitions: IDLE->ERR1 on an error phase; IDLE->WAIT on an OKAY phase when WAIT_STATES>0; otherwise it stays in IDLE with HREADYOUT=1.
REQ-024 WAIT holds HREADYOUT=0 for exactly WAIT_STATES cycles, using a 4-bit down-counter, then returns to IDLE with HREADYOUT=1.
REQ-025 ERR1 drives HREADYOUT=0 and HRESP=1; ERR2 drives HREADYOUT=1 and HRESP=1; the module leaves ERR2 for IDLE, or re-accepts a new address phase presented during ERR2.
REQ-026 Memory is indexed by HADDR[MEM_AWIDTH+1:2]; upper address bits alias.
REQ-027 Writes update only the byte lanes selected by HSIZE/HADDR[1:0], from HWDATA in the final (HREADYOUT=1) data-phase cycle.
REQ-028 Reads drive the addressed word on HRDATA while HREADYOUT=1, unselected lanes included; HRDATA=0 in error and idle cycles.
REQ-029 Back-to-back: a write followed by a read to the same word returns the new data.
REQ-030 Error phases leave the memory unmodified.
REQ-031 Each counter increments once per completed data phase and saturates at 16'hFFFF.
REQ-032 Total latency: an OKAY phase completes WAIT_STATES+1 cycles after address acceptance; an error phase completes in 2.

Reset
REQ-033 HRESET is sampled at HCLK and takes priority over all else: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counters 0, wait counter 0.
REQ-034 Reset mid-data-phase abandons the transfer without writing; memory contents are preserved.

Configuration
REQ-035 Macro AHBL_SLAVE_MEM_STATS_EN defined: STAT_WR, STAT_RD and STAT_ERR counters are implemented.
REQ-036 Macro absent: the STAT_* ports remain and are tied to 0; no counter flops exist.

Structure
REQ-037 Shared package ahbl_pkg holds the HTRANS/HSIZE encodings, the FSM state encoding, and the transfer-record typedef (addr, write, size, lane mask).
REQ-038 One sub-module, ahbl_lane_mask, is combinational: HSIZE and HADDR[1:0] to a 4-bit byte enable plus a misalign flag.

Verification
REQ-039 WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low, STAT_WR=1, STAT_RD=1.
REQ-040 Byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
REQ-041 WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, data on the 4th.
REQ-042 Read 0xFFFF0004 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; STAT_ERR=1; memory unchanged.
REQ-043 Half-word write to 0x21 -> two-cycle ERROR and no memory change.
REQ-044 HRESET asserted in cycle 2 of a 3-wait write -> next cycle HREADYOUT=1; subsequent read returns the old data.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the registered transfer record.
// Imported by ahbl_lane_mask and ahbl_slave_mem.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  be;
  } xfer_t;

  function automatic logic trans_active(input logic [1:0] t);
    logic act;
    act = 1'b0;
    unique case (1'b1)
      t == HTRANS_NONSEQ: act = 1'b1;
      t == HTRANS_SEQ:    act = 1'b1;
      t == HTRANS_IDLE:   act = 1'b0;
      t == HTRANS_BUSY:   act = 1'b0;
      default:            act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahbl_lane_mask.sv
// Byte-lane decoder: size, addr_lo[1:0] in; be[3:0] and misalign flag out.
// Illegal sizes give be=0; the caller flags them separately.
module ahbl_lane_mask
  import ahbl_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misalign
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    unique case (1'b1)
      size == HSIZE_BYTE: begin
        be = 4'b0001 << addr_lo;
      end
      size == HSIZE_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      size == HSIZE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        be       = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite memory slave: HCLK/HRESET, AHB address/data phase in, HRDATA/HREADYOUT/HRESP out,
// STAT_WR/RD/ERR counters when AHBL_SLAVE_MEM_STATS_EN is defined (tied 0 otherwise).
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int unsigned MEM_AWIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_BASE    = 32'hFFFF_0000,
  parameter logic [31:0] ERR_LIMIT   = 32'hFFFF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [15:0] STAT_WR,
  output logic [15:0] STAT_RD,
  output logic [15:0] STAT_ERR
);

  localparam int unsigned DEPTH = 1 << MEM_AWIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_nx;
  logic        busy;
  logic        busy_nx;
  xfer_t       xfer;
  logic [31:0] mem [DEPTH];

  logic [3:0]  be;
  logic        misalign;
  logic        rdy;
  logic        accept;
  logic        bad;
  logic        done;
  logic        wr_en;
  logic [MEM_AWIDTH-1:0] idx;
  logic        unused_ok;

  ahbl_lane_mask u_mask (
    .size     (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .be       (be),
    .misalign (misalign)
  );

  assign rdy    = (state != ST_WAIT) && (state != ST_ERR1);
  assign accept = HSEL & HREADY & rdy & trans_active(HTRANS);
  assign bad    = ((HADDR >= ERR_BASE) && (HADDR <= ERR_LIMIT))
                | (HSIZE > HSIZE_WORD)
                | misalign;

  // busy marks an OKAY data phase; it completes in the IDLE cycle
  assign done  = (state == ST_IDLE) & busy;
  assign wr_en = done & xfer.write & ~HRESET;
  assign idx   = xfer.addr[MEM_AWIDTH+1:2];

  assign HREADYOUT = rdy;
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign HRDATA    = (done && !xfer.write) ? mem[idx] : 32'h0;

  assign unused_ok = ^{HBURST, xfer.size, xfer.addr};

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    busy_nx  = 1'b0;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_nx = ST_IDLE;
        if (accept) begin
          if (bad) begin
            state_nx = ST_ERR1;
          end else begin
            busy_nx = 1'b1;
            if (WS != 4'd0) begin
              state_nx = ST_WAIT;
              wcnt_nx  = WS - 4'd1;
            end
          end
        end
      end
      ST_WAIT: begin
        busy_nx = 1'b1;
        if (wcnt == 4'd0) begin
          state_nx = ST_IDLE;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      ST_ERR1: begin
        state_nx = ST_ERR2;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
      busy  <= 1'b0;
      xfer  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      busy  <= busy_nx;
      if (accept) begin
        xfer.addr  <= HADDR;
        xfer.write <= HWRITE;
        xfer.size  <= HSIZE;
        xfer.be    <= be;
      end
    end
  end

  // memory content survives reset; only the write strobe is gated
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (xfer.be[i]) begin
          mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

`ifdef AHBL_SLAVE_MEM_STATS_EN
  logic [15:0] n_wr;
  logic [15:0] n_rd;
  logic [15:0] n_err;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      n_wr  <= 16'd0;
      n_rd  <= 16'd0;
      n_err <= 16'd0;
    end else begin
      if (done && xfer.write && n_wr != 16'hFFFF) begin
        n_wr <= n_wr + 16'd1;
      end
      if (done && !xfer.write && n_rd != 16'hFFFF) begin
        n_rd <= n_rd + 16'd1;
      end
      if (state == ST_ERR2 && n_err != 16'hFFFF) begin
        n_err <= n_err + 16'd1;
      end
    end
  end

  assign STAT_WR  = n_wr;
  assign STAT_RD  = n_rd;
  assign STAT_ERR = n_err;
`else
  assign STAT_WR  = 16'd0;
  assign STAT_RD  = 16'd0;
  assign STAT_ERR = 16'd0;
`endif

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Randomized bench for ahbl_slave_mem: one zero-wait and one 3-wait instance
// checked against a word-array reference model.
module tb_ahbl_slave_mem;

  localparam logic [31:0] ERR_BASE = 32'hFFFF_0000;
  localparam bit STATS =
`ifdef AHBL_SLAVE_MEM_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst0;
  logic        rst3;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;

  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3;
  logic        resp0, resp3;
  logic [15:0] stw0, str0, ste0;
  logic [15:0] stw3, str3, ste3;

  logic [31:0] mdl [2][1024];
  int nwr [2];
  int nrd [2];
  int nerr [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahbl_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst0), .HSEL(hsel & ~sel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HREADY(rdy0), .HRDATA(rdata0), .HREADYOUT(rdy0),
    .HRESP(resp0), .STAT_WR(stw0), .STAT_RD(str0), .STAT_ERR(ste0)
  );

  ahbl_slave_mem #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst3), .HSEL(hsel & sel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HREADY(rdy3), .HRDATA(rdata3), .HREADYOUT(rdy3),
    .HRESP(resp3), .STAT_WR(stw3), .STAT_RD(str3), .STAT_ERR(ste3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int s);
    @(negedge clk);
    chk({tag, ".wr"}, 32'(s == 1 ? stw3 : stw0), STATS ? 32'(nwr[s]) : 32'h0);
    chk({tag, ".rd"}, 32'(s == 1 ? str3 : str0), STATS ? 32'(nrd[s]) : 32'h0);
    chk({tag, ".err"}, 32'(s == 1 ? ste3 : ste0), STATS ? 32'(nerr[s]) : 32'h0);
  endtask

  // single non-pipelined transfer; lows counts data-phase cycles with HREADYOUT=0
  task automatic bus_xfer(input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd,
                          output logic [31:0] rd, output logic rsp,
                          output int lows);
    @(negedge clk);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    @(negedge clk);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    lows   = 0;
    while (!(sel ? rdy3 : rdy0) && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    rd  = sel ? rdata3 : rdata0;
    rsp = sel ? resp3 : resp0;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] rd);
    logic        rsp;
    int          lows;
    logic        err;
    int          s;
    int          lane;
    logic [31:0] exp_rd;
    s = sel ? 1 : 0;
    bus_xfer(wr, a, sz, wd, rd, rsp, lows);
    err = (a >= ERR_BASE) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
    exp_rd = (!wr && !err) ? mdl[s][a[11:2]] : 32'h0;
    chk({tag, ".lows"}, 32'(lows), err ? 32'd1 : (s == 1 ? 32'd3 : 32'd0));
    chk({tag, ".resp"}, 32'(rsp), 32'(err));
    chk({tag, ".rdata"}, rd, exp_rd);
    if (err) begin
      nerr[s]++;
    end else if (wr) begin
      nwr[s]++;
      for (int k = 0; k < (1 << sz); k++) begin
        lane = int'(a[1:0]) + k;
        mdl[s][a[11:2]][8*lane +: 8] = wd[8*lane +: 8];
      end
    end else begin
      nrd[s]++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  sz;
    logic        w;

    sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = '0;
    rst0 = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nwr[i] = 0; nrd[i] = 0; nerr[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst.rdy0", 32'(rdy0), 32'd1);
    chk("rst.resp0", 32'(resp0), 32'd0);
    chk("rst.rdata0", rdata0, 32'h0);
    chk("rst.rdy3", 32'(rdy3), 32'd1);
    chk("rst.resp3", 32'(resp3), 32'd0);
    chk_stats("rst.st0", 0);
    chk_stats("rst.st3", 1);

    sel = 1'b0;
    do_op("w10", 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd);
    do_op("r10", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    chk("r10.lit", rd, 32'hDEAD_BEEF);
    chk_stats("st.wr_rd", 0);

    do_op("w10b", 1'b1, 32'h10, 3'd2, 32'h1122_3344, rd);
    do_op("wb13", 1'b1, 32'h13, 3'd0, 32'hAA55_6677, rd);
    do_op("r10b", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    chk("byte.lit", rd, 32'hAA22_3344);

    do_op("rerr", 1'b0, 32'hFFFF_0004, 3'd2, 32'h0, rd);
    chk_stats("st.err", 0);
    do_op("werr", 1'b1, 32'hFFFF_0010, 3'd2, 32'h0BAD_0BAD, rd);
    do_op("r10c", 1'b0, 32'h10, 3'd2, 32'h0, rd);
    chk("errw.lit", rd, 32'hAA22_3344);

    do_op("w20", 1'b1, 32'h20, 3'd2, 32'h5566_7788, rd);
    do_op("h21", 1'b1, 32'h21, 3'd1, 32'hFFFF_FFFF, rd);
    do_op("r20", 1'b0, 32'h20, 3'd2, 32'h0, rd);
    chk("mis.lit", rd, 32'h5566_7788);

    // back-to-back write then read of the same word
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h50; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    chk("b2b.wrdy", 32'(rdy0), 32'd1);
    hwdata = 32'h600D_F00D; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b.rrdy", 32'(rdy0), 32'd1);
    chk("b2b.rdata", rdata0, 32'h600D_F00D);
    mdl[0][20] = 32'h600D_F00D;
    nwr[0]++;
    nrd[0]++;
    chk_stats("st.b2b", 0);

    sel = 1'b1;
    do_op("w3_40", 1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, rd);
    do_op("r3_40", 1'b0, 32'h40, 3'd2, 32'h0, rd);
    chk("ws3.lit", rd, 32'hCAFE_F00D);

    // reset during cycle 2 of a 3-wait write
    do_op("w3_30", 1'b1, 32'h30, 3'd2, 32'h0BAD_C0DE, rd);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    chk("rstm.low", 32'(rdy3), 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("rstm.rdy", 32'(rdy3), 32'd1);
    chk("rstm.resp", 32'(resp3), 32'd0);
    chk("rstm.rdata", rdata3, 32'h0);
    nwr[1] = 0; nrd[1] = 0; nerr[1] = 0;
    do_op("r3_30", 1'b0, 32'h30, 3'd2, 32'h0, rd);
    chk("rstm.old", rd, 32'h0BAD_C0DE);
    chk_stats("st.rstm", 1);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) begin
        do_op("init", 1'b1, 32'(i) << 2, 3'd2, $urandom, rd);
      end
    end

    for (int n = 0; n < 80; n++) begin
      sel = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        a  = ERR_BASE | ($urandom & 32'h0000_FFFC);
        sz = 3'd2;
      end else begin
        sz = 3'($urandom_range(0, 3));
        a  = ($urandom & 32'h7FFF_F000)
           | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      end
      do_op("rnd", w, a, sz, $urandom, rd);
    end
    chk_stats("st.end0", 0);
    chk_stats("st.end3", 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
